// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
// Optional feature macro used by the top: ADDER_SERIAL_OVF_EN.
package adder_pkg;

  // Controller states: waiting for operands, stepping chunks, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk steps needed for one operation.
  function automatic int adder_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// Elaboration-time guard: CHUNK must be positive and divide WIDTH exactly,
// and WIDTH must be at least 1.
`define ADDER_CHUNK_CHECK(W, C) \
  if ((W) < 1 || (C) < 1 || ((W) % (C)) != 0) begin : g_chunk_check \
    $error("adder_serial: CHUNK must divide WIDTH exactly"); \
  end

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple full adder. Also reports the carry into
// the most significant bit so the caller can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  // Ripple the carry bit by bit, snapshotting it just before the top bit.
  always_comb begin
    logic c;
    s    = '0;
    cmsb = 1'b0;
    c    = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_serial.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB chunk
// first, carrying between chunks in a register. valid/ready on both sides.
// Optional signed-overflow output enabled by macro ADDER_SERIAL_OVF_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; both are
// forced low while rst is high. Inputs are sampled once at acceptance.
module adder_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result
`ifdef ADDER_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH = adder_nch(WIDTH, CHUNK);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  `ADDER_CHUNK_CHECK(WIDTH, CHUNK)

  // Current controller state, also visible hierarchically for debug.
  state_t           state;
  state_t           state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CHUNK-1:0] x;
  logic [CHUNK-1:0] y;
  logic [CHUNK-1:0] s;
  logic             cout;
  logic             last;
  int               base;
`ifdef ADDER_SERIAL_OVF_EN
  logic             cmsb;
  logic             ovf_q;
`else
  logic             cmsb_unused;
`endif

  assign base = int'(idx) * CHUNK;
  assign x    = a_q[base +: CHUNK];
  assign y    = b_q[base +: CHUNK];
  assign last = (idx == LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (cout),
`ifdef ADDER_SERIAL_OVF_EN
    .cmsb (cmsb)
`else
    .cmsb (cmsb_unused)
`endif
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, then add one chunk per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q[base +: CHUNK] <= s;
          carry                <= cout;
          idx                  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // For subtraction the top bit reports borrow, the inverse of carry-out.
  assign result = {sub_q ^ carry, sum_q};

`ifdef ADDER_SERIAL_OVF_EN
  // Signed overflow captured from the final chunk's MSB carries.
  always_ff @(posedge clk) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state == RUN && last)  ovf_q <= cmsb ^ cout;
  end

  assign ovf = (state == DONE) && !rst && ovf_q;
`endif

endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: directed steps on an 8/2 instance, then random
// traffic on 8/8 and 16/4 instances against a golden model.
module tb_adder_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Directed instance (WIDTH=8, CHUNK=2).
  logic       d_in_valid, d_in_ready, d_sub, d_out_valid, d_out_ready;
  logic [7:0] d_a, d_b;
  logic [8:0] d_result;

  // Random instances share one driver, selected by r_sel.
  int          r_sel;
  logic        r_in_valid, r_sub, r_out_ready;
  logic [15:0] r_a, r_b;
  logic        u1_in_ready, u1_out_valid, u2_in_ready, u2_out_valid;
  logic [8:0]  u1_result;
  logic [16:0] u2_result;
  logic        r_in_ready, r_out_valid;
  logic [16:0] r_result;
  logic        u1_in_valid, u1_out_ready, u2_in_valid, u2_out_ready;

`ifdef ADDER_SERIAL_OVF_EN
  logic d_ovf, unused_ovf1, unused_ovf2;
`endif

  assign u1_in_valid  = (r_sel == 1) && r_in_valid;
  assign u1_out_ready = (r_sel == 1) && r_out_ready;
  assign u2_in_valid  = (r_sel == 2) && r_in_valid;
  assign u2_out_ready = (r_sel == 2) && r_out_ready;
  assign r_in_ready   = (r_sel == 1) ? u1_in_ready  : u2_in_ready;
  assign r_out_valid  = (r_sel == 1) ? u1_out_valid : u2_out_valid;
  assign r_result     = (r_sel == 1) ? {8'd0, u1_result} : u2_result;

  adder_serial #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .sub(d_sub), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .result(d_result)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(d_ovf)
`endif
  );

  adder_serial #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .a(r_a[7:0]), .b(r_b[7:0]), .sub(r_sub), .out_valid(u1_out_valid),
    .out_ready(u1_out_ready), .result(u1_result)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(unused_ovf1)
`endif
  );

  adder_serial #(.WIDTH(16), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
    .a(r_a), .b(r_b), .sub(r_sub), .out_valid(u2_out_valid),
    .out_ready(u2_out_ready), .result(u2_result)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(unused_ovf2)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  logic [16:0] exp_q[$];

  // Golden model: (W+1)-bit result, top bit = carry (add) or borrow (sub).
  function automatic logic [16:0] model(input int w, input logic [15:0] x,
                                        input logic [15:0] y, input logic s);
    logic [16:0] mask, r;
    mask = (17'd1 << w) - 17'd1;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y};
    end else begin
      r = ({1'b0, x} - {1'b0, y}) & mask;
      if (x < y) r = r | (17'd1 << w);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed operation on u0 with out_ready held high.
  task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv);
    int k;
    logic [16:0] e;
    d_a = av; d_b = bv; d_sub = sv; d_in_valid = 1'b1; d_out_ready = 1'b1;
    k = 0;
    while (!d_in_ready && k < 20) begin tick(); k++; end
    check({tag, "_in_ready"}, d_in_ready, 1);
    e = model(8, 16'(av), 16'(bv), sv);
    exp_q.push_back(e);
    tick();
    // Operands changing after acceptance must not matter.
    d_in_valid = 1'b0;
    d_a = 8'($urandom); d_b = 8'($urandom); d_sub = 1'($urandom);
    k = 1;
    while (!d_out_valid && k < 20) begin tick(); k++; end
    check({tag, "_latency"}, k, 5);
    if (exp_q.size() == 0) check({tag, "_queue"}, 0, 1);
    else check({tag, "_result"}, d_result, exp_q.pop_front());
`ifdef ADDER_SERIAL_OVF_EN
    if (!sv) check({tag, "_ovf"}, d_ovf, (av[7] == bv[7]) && (e[7] != av[7]));
    else     check({tag, "_ovf"}, d_ovf, (av[7] != bv[7]) && (e[7] != av[7]));
`endif
    tick();
    check({tag, "_ready_after"}, d_in_ready, 1);
    check({tag, "_valid_after"}, d_out_valid, 0);
`ifdef ADDER_SERIAL_OVF_EN
    check({tag, "_ovf_idle"}, d_ovf, 0);
`endif
  endtask

  // Random traffic with random valid/ready on the selected instance.
  task automatic rand_ops(input int sel, input int w, input int lat, input int n);
    int done_n = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic seen = 1'b0;
    logic took;
    logic [16:0] mask;
    mask = (17'd1 << w) - 17'd1;
    r_sel = sel;
    r_in_valid = 1'b0;
    r_out_ready = 1'b0;
    while (done_n < n && cyc < n * 30) begin
      if (!r_in_valid && $urandom_range(0, 9) < 7) begin
        r_in_valid = 1'b1;
        r_a = 16'($urandom) & mask[15:0];
        r_b = 16'($urandom) & mask[15:0];
        r_sub = 1'($urandom_range(0, 1));
      end
      r_out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (r_out_valid && !seen) begin
        seen = 1'b1;
        check("rand_latency", cyc - acc_cyc, lat);
      end
      if (r_out_valid && r_out_ready) begin
        if (exp_q.size() == 0) check("rand_queue", 0, 1);
        else check("rand_result", r_result, exp_q.pop_front());
        done_n++;
        seen = 1'b0;
      end
      took = r_in_valid && r_in_ready;
      if (took) begin
        exp_q.push_back(model(w, r_a, r_b, r_sub));
        acc_cyc = cyc;
      end
      tick();
      cyc++;
      if (took) r_in_valid = 1'b0;
    end
    r_in_valid = 1'b0;
    r_out_ready = 1'b0;
    check("rand_completed", done_n, n);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_out_ready = 1'b0;
    r_sel = 0; r_in_valid = 1'b0; r_a = '0; r_b = '0; r_sub = 1'b0; r_out_ready = 1'b0;
    #1;
    check("rst_in_ready_pre", d_in_ready, 0);
    tick(); tick();
    check("rst_in_ready", d_in_ready, 0);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_result", d_result, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", d_in_ready, 1);

    // Basic add with carry-out, then subtraction cases.
    op_check("add_ff_01", 8'hFF, 8'h01, 1'b0);
    op_check("sub_05_07", 8'h05, 8'h07, 1'b1);
    op_check("sub_07_05", 8'h07, 8'h05, 1'b1);
    op_check("sub_33_33", 8'h33, 8'h33, 1'b1);

    // Backpressure: hold the result for six cycles, poke in_valid meanwhile.
    d_out_ready = 1'b0;
    d_a = 8'h12; d_b = 8'h34; d_sub = 1'b0; d_in_valid = 1'b1;
    check("bp_accept", d_in_ready, 1);
    exp_q.push_back(model(8, 16'h12, 16'h34, 1'b0));
    tick();
    d_in_valid = 1'b0;
    k = 1;
    while (!d_out_valid && k < 20) begin tick(); k++; end
    check("bp_latency", k, 5);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", d_out_valid, 1);
      check("bp_in_ready", d_in_ready, 0);
      check("bp_result", d_result, exp_q[0]);
      d_in_valid = 1'b1; d_a = 8'($urandom); d_b = 8'($urandom); d_sub = 1'($urandom);
      tick();
    end
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    check("bp_result_final", d_result, exp_q.pop_front());
    tick();
    check("bp_release_ready", d_in_ready, 1);
    check("bp_release_valid", d_out_valid, 0);
    op_check("after_bp", 8'h9C, 8'h2B, 1'b1);

    // Reset during the second RUN cycle discards the operation.
    d_a = 8'hAA; d_b = 8'h55; d_sub = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
    check("mid_accept", d_in_ready, 1);
    tick();
    d_in_valid = 1'b0;
    check("mid_busy", d_in_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", d_in_ready, 0);
    check("mid_rst_valid", d_out_valid, 0);
    tick();
    check("mid_rst_ready2", d_in_ready, 0);
    check("mid_rst_result", d_result, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_no_valid", d_out_valid, 0);
      check("mid_ready", d_in_ready, 1);
    end
    op_check("post_mid_rst", 8'h10, 8'h20, 1'b0);

    // Signed-overflow corner operands.
    op_check("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
    op_check("ovf_80_01", 8'h80, 8'h01, 1'b1);
    op_check("ovf_10_10", 8'h10, 8'h10, 1'b0);

    // Random traffic: single-chunk and four-chunk configurations.
    rand_ops(1, 8, 2, 1000);
    rand_ops(2, 16, 5, 1000);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
